// File: rtl/tmp_decim.sv
// Temperature-sensor decimator: counts sink/source packets per frame and hands out (sink, total) over valid/ready.
// Optional comparator cross-check is compiled in with TMP_DECIM_CMPCHK_EN.
module tmp_decim #(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PI2,
    input  logic             PA,
    input  logic             snk,
    input  logic             src_n,
    input  logic             cmp,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] data,
    output logic [CNT_W-1:0] total,
    output logic             overrun,
    output logic             busy,
    output logic [7:0]       err
);

    localparam int unsigned TOT_W = CNT_W + 1;
    localparam int unsigned ERR_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TOT_W-1:0] FRAME_LIM = TOT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_LATCH = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_snk_d;
    logic r_src_n_d;
    logic r_pi2_d;
    logic r_pa_d;

    logic [CNT_W-1:0] r_snk_cnt;
    logic [CNT_W-1:0] r_src_cnt;
    logic [CNT_W-1:0] r_tot_cnt;

    logic             r_valid;
    logic [CNT_W-1:0] r_data;
    logic [CNT_W-1:0] r_total;
    logic             r_overrun;
    logic             r_busy;
    logic [ERR_W-1:0] r_err;

    logic             w_pi2_rise;
    logic             w_pa_rise;
    logic             w_count_en;
    logic             w_snk_inc;
    logic             w_src_inc;
    logic [CNT_W-1:0] w_snk_nxt;
    logic [CNT_W-1:0] w_src_nxt;
    logic [TOT_W-1:0] w_tot_sum;
    logic [CNT_W-1:0] w_tot_nxt;
    logic             w_frame_full;
    logic             w_handshake;
    logic             w_slot_free;
    logic [ERR_W-1:0] w_err_frame;

    assign w_pi2_rise = PI2 & ~r_pi2_d;
    assign w_pa_rise  = PA & ~r_pa_d;
    assign w_count_en = (r_state == S_ACCUM) & PI2;
    assign w_snk_inc  = w_count_en & (snk ^ r_snk_d);
    assign w_src_inc  = w_count_en & (src_n ^ r_src_n_d);

    // Saturating packet counters and total for this cycle
    assign w_snk_nxt = (w_snk_inc && (r_snk_cnt != CNT_MAX)) ? r_snk_cnt + CNT_W'(1) : r_snk_cnt;
    assign w_src_nxt = (w_src_inc && (r_src_cnt != CNT_MAX)) ? r_src_cnt + CNT_W'(1) : r_src_cnt;
    assign w_tot_sum = TOT_W'(w_snk_nxt) + TOT_W'(w_src_nxt);
    assign w_tot_nxt = (w_tot_sum > TOT_W'(CNT_MAX)) ? CNT_MAX : w_tot_sum[CNT_W-1:0];

    assign w_frame_full = (r_state == S_ACCUM) && (w_tot_sum >= FRAME_LIM);
    assign w_handshake  = r_valid & ready;
    assign w_slot_free  = ~r_valid | ready;

    // Edge-detect history, updated in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snk_d   <= 1'b0;
            r_src_n_d <= 1'b0;
            r_pi2_d   <= 1'b0;
            r_pa_d    <= 1'b0;
        end else begin
            r_snk_d   <= snk;
            r_src_n_d <= src_n;
            r_pi2_d   <= PI2;
            r_pa_d    <= PA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pi2_rise) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_pa_rise || w_frame_full) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!PA) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame counters: cleared in IDLE, frozen outside ACCUM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snk_cnt <= '0;
            r_src_cnt <= '0;
            r_tot_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_snk_cnt <= '0;
            r_src_cnt <= '0;
            r_tot_cnt <= '0;
        end else if (r_state == S_ACCUM) begin
            r_snk_cnt <= w_snk_nxt;
            r_src_cnt <= w_src_nxt;
            r_tot_cnt <= w_tot_nxt;
        end
    end

`ifdef TMP_DECIM_CMPCHK_EN
    logic             r_cmp_m;
    logic             r_cmp_s;
    logic [ERR_W-1:0] r_err_cnt;
    logic [1:0]       w_err_add;
    logic [ERR_W:0]   w_err_sum;

    // Sink packets expect cmp low, source packets expect cmp high
    assign w_err_add = {1'b0, w_snk_inc & r_cmp_s} + {1'b0, w_src_inc & ~r_cmp_s};
    assign w_err_sum = {1'b0, r_err_cnt} + (ERR_W + 1)'(w_err_add);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmp_m   <= 1'b0;
            r_cmp_s   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_cmp_m <= cmp;
            r_cmp_s <= r_cmp_m;
            if (r_state == S_IDLE) begin
                r_err_cnt <= '0;
            end else if (r_state == S_ACCUM) begin
                r_err_cnt <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
            end
        end
    end

    assign w_err_frame = r_err_cnt;
`else
    logic w_unused_cmp;

    assign w_unused_cmp = cmp;
    assign w_err_frame  = '0;
`endif

    // Output slot: a LATCH load in the handshake cycle wins over the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_total   <= '0;
            r_overrun <= 1'b0;
            r_err     <= '0;
        end else begin
            if (w_handshake) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (r_state == S_LATCH) begin
                if (w_slot_free) begin
                    r_valid <= 1'b1;
                    r_data  <= r_snk_cnt;
                    r_total <= r_tot_cnt;
                    r_err   <= w_err_frame;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_ACCUM) || (w_state_nxt == S_LATCH);
        end
    end

    assign valid   = r_valid;
    assign data    = r_data;
    assign total   = r_total;
    assign overrun = r_overrun;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_tmp_decim.sv
// Self-checking bench for tmp_decim: per-frame packet lists scored against an arithmetic frame model.
module tb_tmp_decim;

    localparam int CNT_W     = 12;
    localparam int FRAME_LEN = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             PI2, PA, snk, src_n, cmp, ready;
    logic             valid, overrun, busy;
    logic [CNT_W-1:0] data, total;
    logic [7:0]       err;

    int errors = 0;
    int checks = 0;

    bit q_snk[$];
    bit q_src[$];
    int exp_data, exp_total, exp_err;
    bit exp_full;

    tmp_decim #(.CNT_W(CNT_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset(reset), .PI2(PI2), .PA(PA), .snk(snk), .src_n(src_n),
        .cmp(cmp), .ready(ready), .valid(valid), .data(data), .total(total),
        .overrun(overrun), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: packets accumulate until the total reaches FRAME_LEN
    function automatic void model(input bit c);
        int s = 0;
        int r = 0;
        int e = 0;
        for (int i = 0; i < q_snk.size(); i++) begin
            if (s + r >= FRAME_LEN) break;
            s += int'(q_snk[i]);
            r += int'(q_src[i]);
            e += int'(q_snk[i] & c) + int'(q_src[i] & ~c);
        end
        exp_data  = s;
        exp_total = s + r;
        exp_full  = (s + r >= FRAME_LEN);
`ifdef TMP_DECIM_CMPCHK_EN
        exp_err = (e > 255) ? 255 : e;
`else
        exp_err = 0;
`endif
    endfunction

    task automatic fill(input int n_snk, input int n_src, input int n_both);
        q_snk.delete();
        q_src.delete();
        for (int i = 0; i < n_both; i++) begin q_snk.push_back(1'b1); q_src.push_back(1'b1); end
        for (int i = 0; i < n_snk; i++)  begin q_snk.push_back(1'b1); q_src.push_back(1'b0); end
        for (int i = 0; i < n_src; i++)  begin q_snk.push_back(1'b0); q_src.push_back(1'b1); end
    endtask

    task automatic open_frame();
        PI2 = 1'b1;
        step();
    endtask

    task automatic play();
        for (int i = 0; i < q_snk.size(); i++) begin
            snk   = snk ^ q_snk[i];
            src_n = src_n ^ q_src[i];
            step();
        end
    endtask

    task automatic close_pa();
        PA  = 1'b1;
        PI2 = 1'b0;
        step();
        step();
    endtask

    task automatic end_wait();
        PA = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        PI2 = 0; PA = 0; snk = 0; src_n = 0; cmp = 0; ready = 0;
        step(); step();
        checks++; if ({valid, overrun, busy} !== 3'b000) begin errors++; $display("FAIL por_flags: got %b exp 000", {valid, overrun, busy}); end
        checks++; if ({data, total, err} !== '0) begin errors++; $display("FAIL por_words: got %0d/%0d/%0d exp 0/0/0", data, total, err); end
        reset = 1'b1;
        step();
        // leave a result pending, then reset in the middle of the next frame
        fill(3, 0, 0); open_frame(); play(); close_pa(); end_wait();
        fill(4, 3, 0); open_frame(); play();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b exp 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if ({valid, overrun, busy} !== 3'b000) begin errors++; $display("FAIL async_flags: got %b exp 000", {valid, overrun, busy}); end
        checks++; if ({data, total, err} !== '0) begin errors++; $display("FAIL async_words: got %0d/%0d/%0d exp 0/0/0", data, total, err); end
        PI2 = 1'b0;
        step();
        reset = 1'b1;
        step();
        fill(2, 0, 0); open_frame(); play(); close_pa();
        checks++; if (data !== 12'd2) begin errors++; $display("FAIL post_reset_data: got %0d exp 2", data); end
        ready = 1'b1; step(); ready = 1'b0;
        end_wait();
    endtask

    task automatic test_basic();
        fill(5, 3, 0);
        model(1'b0);
        ready = 1'b1;
        open_frame(); play();
        PA = 1'b1; PI2 = 1'b0;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_n1_valid: got %b exp 0", valid); end
        step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_n2_valid: got %b exp 1", valid); end
        checks++; if (data !== 12'(exp_data) || data !== 12'd5) begin errors++; $display("FAIL basic_data: got %0d exp %0d", data, exp_data); end
        checks++; if (total !== 12'(exp_total) || total !== 12'd8) begin errors++; $display("FAIL basic_total: got %0d exp %0d", total, exp_total); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b exp 0", valid); end
        ready = 1'b0;
        end_wait();
    endtask

    task automatic test_simultaneous();
        fill(0, 0, 4);
        open_frame(); play(); close_pa();
        checks++; if (data !== 12'd4) begin errors++; $display("FAIL simul_data: got %0d exp 4", data); end
        checks++; if (total !== 12'd8) begin errors++; $display("FAIL simul_total: got %0d exp 8", total); end
        ready = 1'b1; step(); ready = 1'b0;
        end_wait();
    endtask

    task automatic test_frame_len();
        fill(20, 0, 0);
        open_frame(); play();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL flen_valid: got %b exp 1", valid); end
        checks++; if (data !== 12'd16) begin errors++; $display("FAIL flen_data: got %0d exp 16", data); end
        checks++; if (total !== 12'd16) begin errors++; $display("FAIL flen_total: got %0d exp 16", total); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flen_busy: got %b exp 0", busy); end
        ready = 1'b1; step(); ready = 1'b0;
        PI2 = 1'b0; step();
        // WAIT must already have returned to IDLE with PA low
        fill(2, 1, 0); open_frame(); play();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flen_reopen: got %b exp 1", busy); end
        close_pa();
        checks++; if (total !== 12'd3) begin errors++; $display("FAIL flen_next_total: got %0d exp 3", total); end
        ready = 1'b1; step(); ready = 1'b0;
        end_wait();
    endtask

    task automatic test_overrun();
        fill(3, 0, 0); open_frame(); play(); close_pa(); end_wait();
        fill(6, 0, 0); open_frame(); play(); close_pa(); end_wait();
        checks++; if ({valid, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_flags: got %b exp 11", {valid, overrun}); end
        checks++; if (data !== 12'd3 || total !== 12'd3) begin errors++; $display("FAIL ovr_held: got %0d/%0d exp 3/3", data, total); end
        ready = 1'b1; step(); ready = 1'b0;
        checks++; if ({valid, overrun} !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b exp 00", {valid, overrun}); end
        checks++; if (data !== 12'd3) begin errors++; $display("FAIL ovr_data_stable: got %0d exp 3", data); end
    endtask

    task automatic test_cmp();
        cmp = 1'b1;
        step(); step(); step();
        fill(4, 2, 0);
        model(1'b1);
        open_frame(); play(); close_pa();
        checks++; if (data !== 12'd4 || total !== 12'd6) begin errors++; $display("FAIL cmp_counts: got %0d/%0d exp 4/6", data, total); end
        checks++; if (err !== 8'(exp_err)) begin errors++; $display("FAIL cmp_err: got %0d exp %0d", err, exp_err); end
        ready = 1'b1; step(); ready = 1'b0;
        end_wait();
        cmp = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int n;
            bit c;
            n = int'($urandom_range(0, 24));
            c = 1'($urandom_range(0, 1));
            cmp = c;
            step(); step(); step();
            q_snk.delete();
            q_src.delete();
            for (int i = 0; i < n; i++) begin
                q_snk.push_back(1'($urandom_range(0, 1)));
                q_src.push_back(1'($urandom_range(0, 1)));
            end
            model(c);
            open_frame(); play();
            checks++; if (busy !== !exp_full) begin errors++; $display("FAIL rnd%0d_busy: got %b exp %b", f, busy, !exp_full); end
            close_pa();
            checks++; if (valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL rnd%0d_flags: got %b%b exp 10", f, valid, overrun); end
            checks++; if (data !== 12'(exp_data) || total !== 12'(exp_total)) begin errors++; $display("FAIL rnd%0d_counts: got %0d/%0d exp %0d/%0d", f, data, total, exp_data, exp_total); end
            checks++; if (err !== 8'(exp_err)) begin errors++; $display("FAIL rnd%0d_err: got %0d exp %0d", f, err, exp_err); end
            ready = 1'b1; step(); ready = 1'b0;
            end_wait();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_frame_len();
        test_overrun();
        test_cmp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
